// File: rtl/instr_encoder_fifo.sv
// ALU request encoder feeding a small instruction FIFO.
// Illegal alu_op requests are consumed, dropped and flagged.
module instr_encoder_fifo #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       req_valid,
   output logic                       req_ready,
   input  logic [2:0]                 req_alu_op,
   input  logic [2:0]                 req_rd,
   input  logic [2:0]                 req_rs1,
   input  logic [2:0]                 req_rs2,
   output logic                       instr_valid,
   input  logic                       instr_ready,
   output logic [18:0]                instr,
   output logic                       illegal_pulse,
   output logic [$clog2(DEPTH):0]     occupancy,
   output logic [CNT_W-1:0]           issued_count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int OCC_W = PTR_W + 1;

   logic [18:0]      mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [OCC_W-1:0] occ;

   logic             req_fire;
   logic             legal;
   logic             push;
   logic             pop;
   logic [18:0]      word;

   function automatic logic [4:0] opcode_of(input logic [1:0] op);
      logic [4:0] oc;
      oc = 5'b00000;
      unique case (op)
         2'b00: oc = 5'b00000;
         2'b01: oc = 5'b00001;
         2'b10: oc = 5'b00010;
         2'b11: oc = 5'b00011;
         default: oc = 5'b00000;
      endcase
      return oc;
   endfunction

   // Handshake decisions use registered occupancy only; no full bypass.
   assign req_ready   = (occ != OCC_W'(DEPTH));
   assign instr_valid = (occ != '0);
   assign req_fire    = req_valid && req_ready;
   assign legal       = !req_alu_op[2];
   assign push        = req_fire && legal;
   assign pop         = instr_valid && instr_ready;
   assign occupancy   = occ;

   assign word = {opcode_of(req_alu_op[1:0]),
                  req_rd, req_rs1, req_rs2, 5'b00000};

   assign instr = instr_valid ? mem[rd_ptr] : 19'h0;

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= word;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         unique case ({push, pop})
            2'b10:   occ <= occ + 1'b1;
            2'b01:   occ <= occ - 1'b1;
            default: occ <= occ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         illegal_pulse <= 1'b0;
         issued_count  <= '0;
      end else begin
         illegal_pulse <= req_fire && !legal;
         if (pop) begin
            issued_count <= issued_count + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_instr_encoder_fifo.sv
// Randomized bench for instr_encoder_fifo with a queue-based model.
// Model advances on each rising edge; outputs are compared on falling edges.
module tb_instr_encoder_fifo;

   localparam int DEPTH = 4;
   localparam int CNT_W = 16;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  req_alu_op;
   logic [2:0]  req_rd;
   logic [2:0]  req_rs1;
   logic [2:0]  req_rs2;
   logic        instr_valid;
   logic        instr_ready;
   logic [18:0] instr;
   logic        illegal_pulse;
   logic [2:0]  occupancy;
   logic [15:0] issued_count;

   int checks;
   int errors;
   bit cmp_en;

   logic [18:0] q[$];
   bit          m_ill;
   int          m_issued;

   instr_encoder_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_alu_op   (req_alu_op),
      .req_rd       (req_rd),
      .req_rs1      (req_rs1),
      .req_rs2      (req_rs2),
      .instr_valid  (instr_valid),
      .instr_ready  (instr_ready),
      .instr        (instr),
      .illegal_pulse(illegal_pulse),
      .occupancy    (occupancy),
      .issued_count (issued_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [18:0] enc(input int op, input int rd,
                                       input int rs1, input int rs2);
      return 19'(op * 16384 + rd * 2048 + rs1 * 256 + rs2 * 32);
   endfunction

   // Reference model: a plain queue of encoded words.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q.delete();
         m_ill    = 0;
         m_issued = 0;
      end else begin
         automatic bit acc = req_valid && (q.size() != DEPTH);
         automatic bit ill = acc && (req_alu_op >= 3'd4);
         automatic bit pp  = (q.size() != 0) && instr_ready;
         if (pp) begin
            void'(q.pop_front());
            m_issued = (m_issued + 1) % 65536;
         end
         if (acc && !ill) begin
            q.push_back(enc(req_alu_op, req_rd, req_rs1, req_rs2));
         end
         m_ill = ill;
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("occupancy", 32'(occupancy), 32'(q.size()));
         chk("instr_valid", 32'(instr_valid), 32'(q.size() != 0));
         chk("req_ready", 32'(req_ready), 32'(q.size() != DEPTH));
         chk("instr", 32'(instr), (q.size() != 0) ? 32'(q[0]) : 32'd0);
         chk("illegal_pulse", 32'(illegal_pulse), 32'(m_ill));
         chk("issued_count", 32'(issued_count), 32'(m_issued));
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic req(input bit v, input int op, input int rd,
                      input int rs1, input int rs2);
      req_valid  = v;
      req_alu_op = 3'(op);
      req_rd     = 3'(rd);
      req_rs1    = 3'(rs1);
      req_rs2    = 3'(rs2);
   endtask

   task automatic at_neg();
      @(negedge clk);
      #1;
   endtask

   initial begin
      checks      = 0;
      errors      = 0;
      cmp_en      = 0;
      rst_n       = 1'b0;
      instr_ready = 1'b0;
      req(0, 0, 0, 0, 0);
      #3;
      chk("rst occupancy", 32'(occupancy), 0);
      chk("rst instr_valid", 32'(instr_valid), 0);
      chk("rst instr", 32'(instr), 0);
      chk("rst req_ready", 32'(req_ready), 1);
      chk("rst issued", 32'(issued_count), 0);
      chk("rst illegal", 32'(illegal_pulse), 0);
      @(negedge clk);
      rst_n  = 1'b1;
      cmp_en = 1;
      cyc();

      // Encode one of each legal op
      instr_ready = 1'b1;
      req(1, 0, 1, 2, 3);
      cyc();
      req(0, 0, 0, 0, 0);
      at_neg();
      chk("enc ADD", 32'(instr), 32'(19'b00000_001_010_011_00000));
      cyc();
      req(1, 1, 7, 0, 5);
      cyc();
      req(0, 0, 0, 0, 0);
      at_neg();
      chk("enc SUB", 32'(instr), 32'(19'b00001_111_000_101_00000));
      cyc();
      req(1, 2, 4, 6, 1);
      cyc();
      req(0, 0, 0, 0, 0);
      at_neg();
      chk("enc AND", 32'(instr), 32'(19'b00010_100_110_001_00000));
      cyc();
      req(1, 3, 2, 5, 7);
      cyc();
      req(0, 0, 0, 0, 0);
      at_neg();
      chk("enc OR", 32'(instr), 32'(19'b00011_010_101_111_00000));
      cyc();
      cyc();

      // Fill and hold off the fifth request
      instr_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         req(1, i, i + 1, i + 2, i + 3);
         cyc();
      end
      req(1, 0, 7, 7, 7);
      cyc();
      cyc();
      at_neg();
      chk("fill occupancy", 32'(occupancy), 4);
      chk("fill req_ready", 32'(req_ready), 0);
      chk("fill head", 32'(instr), 32'(19'b00000_001_010_011_00000));
      req(0, 0, 0, 0, 0);
      instr_ready = 1'b1;
      for (int i = 0; i < 5; i++) cyc();
      at_neg();
      chk("drain issued", 32'(issued_count), 8);
      chk("drain empty", 32'(occupancy), 0);

      // Illegal request
      req(1, 5, 1, 1, 1);
      cyc();
      req(0, 0, 0, 0, 0);
      at_neg();
      chk("illegal pulse", 32'(illegal_pulse), 1);
      chk("illegal occ", 32'(occupancy), 0);
      chk("illegal no word", 32'(instr_valid), 0);
      cyc();
      at_neg();
      chk("illegal one cycle", 32'(illegal_pulse), 0);

      // Concurrent push and pop at occupancy 2
      instr_ready = 1'b0;
      req(1, 1, 1, 1, 1);
      cyc();
      cyc();
      instr_ready = 1'b1;
      req(1, 2, 2, 2, 2);
      cyc();
      req(0, 0, 0, 0, 0);
      instr_ready = 1'b0;
      at_neg();
      chk("concurrent occ", 32'(occupancy), 2);
      cyc();

      // Random traffic, including illegal bursts and wrap
      for (int i = 0; i < 600; i++) begin
         req($urandom_range(0, 3) != 0, $urandom_range(0, 7),
             $urandom_range(0, 7), $urandom_range(0, 7),
             $urandom_range(0, 7));
         instr_ready = ($urandom_range(0, 2) != 0);
         cyc();
      end

      // Mid-stream reset at occupancy 3
      req(0, 0, 0, 0, 0);
      instr_ready = 1'b1;
      for (int i = 0; i < 6; i++) cyc();
      instr_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         req(1, 3, i, i, i);
         cyc();
      end
      req(0, 0, 0, 0, 0);
      at_neg();
      chk("pre-reset occ", 32'(occupancy), 3);
      cyc();
      rst_n = 1'b0;
      #2;
      chk("mid rst occ", 32'(occupancy), 0);
      chk("mid rst valid", 32'(instr_valid), 0);
      chk("mid rst instr", 32'(instr), 0);
      chk("mid rst ready", 32'(req_ready), 1);
      chk("mid rst issued", 32'(issued_count), 0);
      @(negedge clk);
      rst_n = 1'b1;
      cyc();
      instr_ready = 1'b1;
      req(1, 0, 3, 2, 1);
      cyc();
      req(0, 0, 0, 0, 0);
      at_neg();
      chk("post-reset ADD", 32'(instr), 32'(19'b00000_011_010_001_00000));
      chk("post-reset occ", 32'(occupancy), 1);
      cyc();
      cyc();
      cmp_en = 0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
